alu_operand_loader: RTL

- Upstream input stage for the 8-bit ALU.
- Captures operand A, operand B and a one-hot opcode from board switches and five push buttons using a sequential entry procedure.
- Holds them stable on registered outputs that drive the ALU's A, B and opcode inputs directly.
- Contains per-button synchronisation, debounce and rising-edge detection, plus the entry FSM.

---
 rtl/alu_operand_loader.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/alu_operand_loader.sv
// Operand/opcode entry front-end for the 8-bit ALU: per-button sync + debounce + edge detect, then a 4-state entry FSM.
// Optional build macro ALU_OPCODE_LIVE_EN lets a direction press in SHOW replace the opcode without re-entering operands.
module alu_operand_loader #(
    parameter int unsigned DEBOUNCE_CYCLES = 16'd50000,
    parameter int unsigned CNT_W           = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] sw,
    input  logic       btn_enter,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_right,
    input  logic       btn_left,
    output logic [7:0] operand_a,
    output logic [7:0] operand_b,
    output logic [3:0] opcode,
    output logic [1:0] stage,
    output logic       op_valid
);

    localparam int NUM_BTN   = 5;
    localparam int BTN_ENTER = 4;
    localparam logic [CNT_W-1:0] DB_LIMIT = CNT_W'(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {
        LOAD_A  = 2'd0,
        LOAD_B  = 2'd1,
        LOAD_OP = 2'd2,
        SHOW    = 2'd3
    } state_t;

    // Bit order puts each direction button on the opcode bit it selects.
    logic [NUM_BTN-1:0] btn_raw;
    assign btn_raw = {btn_enter, btn_up, btn_down, btn_right, btn_left};

    logic [NUM_BTN-1:0] sync1_q, sync1_d;
    logic [NUM_BTN-1:0] sync2_q, sync2_d;
    logic [NUM_BTN-1:0] db_q, db_d;
    logic [NUM_BTN-1:0] db_prev_q, db_prev_d;
    logic [CNT_W-1:0]   cnt_q [NUM_BTN];
    logic [CNT_W-1:0]   cnt_d [NUM_BTN];
    logic [NUM_BTN-1:0] pulse;

    state_t     state_q, state_d;
    logic [7:0] operand_a_q, operand_a_d;
    logic [7:0] operand_b_q, operand_b_d;
    logic [3:0] opcode_q, opcode_d;

    logic [3:0] dir_pulse;
    logic       enter_pulse;
    logic       dir_single;

    function automatic logic is_onehot4(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
    endfunction

    always_comb begin
        sync1_d   = btn_raw;
        sync2_d   = sync1_q;
        db_prev_d = db_q;
        db_d      = db_q;
        for (int i = 0; i < NUM_BTN; i++) begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
            if (sync2_q[i] == db_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == DB_LIMIT) begin
                db_d[i]  = sync2_q[i];
                cnt_d[i] = '0;
            end
        end
    end

    assign pulse       = db_q & ~db_prev_q;
    assign dir_pulse   = pulse[3:0];
    assign enter_pulse = pulse[BTN_ENTER];
    assign dir_single  = is_onehot4(dir_pulse);

    // Direction wins over enter in LOAD_OP; enter wins everywhere else.
    always_comb begin
        state_d     = state_q;
        operand_a_d = operand_a_q;
        operand_b_d = operand_b_q;
        opcode_d    = opcode_q;
        case (state_q)
            LOAD_A: begin
                if (enter_pulse) begin
                    operand_a_d = sw;
                    state_d     = LOAD_B;
                end
            end
            LOAD_B: begin
                if (enter_pulse) begin
                    operand_b_d = sw;
                    state_d     = LOAD_OP;
                end
            end
            LOAD_OP: begin
                if (dir_single) begin
                    opcode_d = dir_pulse;
                    state_d  = SHOW;
                end
            end
            SHOW: begin
                if (enter_pulse) begin
                    opcode_d = 4'b0000;
                    state_d  = LOAD_A;
                end
`ifdef ALU_OPCODE_LIVE_EN
                else if (dir_single) begin
                    opcode_d = dir_pulse;
                end
`endif
            end
            default: begin
                state_d = LOAD_A;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            db_q        <= '0;
            db_prev_q   <= '0;
            for (int i = 0; i < NUM_BTN; i++) begin
                cnt_q[i] <= '0;
            end
            state_q     <= LOAD_A;
            operand_a_q <= '0;
            operand_b_q <= '0;
            opcode_q    <= '0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            db_q        <= db_d;
            db_prev_q   <= db_prev_d;
            for (int i = 0; i < NUM_BTN; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            state_q     <= state_d;
            operand_a_q <= operand_a_d;
            operand_b_q <= operand_b_d;
            opcode_q    <= opcode_d;
        end
    end

    assign operand_a = operand_a_q;
    assign operand_b = operand_b_q;
    assign opcode    = opcode_q;
    assign stage     = state_q;
    assign op_valid  = (state_q == SHOW) && (opcode_q != 4'b0000);

endmodule
